// File: rtl/clock_set_controller.sv
// Key-driven time/alarm set-mode controller for the digital clock; owns the BCD working registers.
// Optional hold-to-repeat on key_inc is built when AUTO_REPEAT_EN is defined.
module clock_set_controller #(
    parameter int TIMEOUT    = 20,
    parameter int HOLD_TICKS = 4
) (
    input  logic       clk_2hz,
    input  logic       cr,
    input  logic       en,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_confirm,
    input  logic [7:0] clock_hour,
    input  logic [7:0] clock_minute,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    output logic [7:0] set_hour,
    output logic [7:0] set_minute,
    output logic       clock_load,
    output logic       set_confirm,
    output logic [1:0] alarm_set_select,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } state_t;

    state_t          state, next_state;
    logic            mode_q, inc_q, conf_q;
    logic [IW-1:0]   idle_cnt, next_idle;
    logic [7:0]      next_hour, next_minute;
    logic            next_load, next_conf, next_blink;
    logic [1:0]      next_field;
    logic            conf_ev, mode_ev, inc_ev, inc_trig;

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[7:4];
        o = v[3:0];
        // Out-of-range values and 23 both collapse to 00.
        if (t > 4'd2 || o > 4'd9 || (t == 4'd2 && o >= 4'd3)) return 8'h00;
        else if (o == 4'd9)                                   return {t + 4'd1, 4'd0};
        else                                                   return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] inc_minute(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[7:4];
        o = v[3:0];
        if (t > 4'd5 || o > 4'd9 || (t == 4'd5 && o == 4'd9)) return 8'h00;
        else if (o == 4'd9)                                   return {t + 4'd1, 4'd0};
        else                                                   return {t, o + 4'd1};
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            T_HOUR, A_HOUR: return 2'b01;
            T_MIN,  A_MIN:  return 2'b10;
            default:        return 2'b00;
        endcase
    endfunction

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    logic [HW-1:0] hold_cnt;

    // Counts held cycles after the rising edge and saturates; repeats fire while saturated.
    always_ff @(posedge clk_2hz or negedge cr) begin
        if (!cr)                           hold_cnt <= '0;
        else if (!key_inc || !inc_q)       hold_cnt <= '0;
        else if (hold_cnt != HW'(HOLD_TICKS)) hold_cnt <= hold_cnt + 1'b1;
    end

    assign inc_trig = (key_inc & ~inc_q) | (key_inc & inc_q & (hold_cnt == HW'(HOLD_TICKS)));
`else
    assign inc_trig = key_inc & ~inc_q;
`endif

    always_comb begin
        conf_ev = en & key_confirm & ~conf_q;
        mode_ev = en & key_mode & ~mode_q & ~conf_ev;
        inc_ev  = en & inc_trig & ~conf_ev & ~mode_ev;
    end

    always_comb begin
        next_state  = state;
        next_hour   = set_hour;
        next_minute = set_minute;
        next_load   = 1'b0;
        next_conf   = 1'b0;
        next_idle   = idle_cnt;
        if (!en) begin
            next_state = RUN;
            next_idle  = '0;
        end else if (state == RUN) begin
            next_idle = '0;
            if (mode_ev) begin
                next_state  = T_HOUR;
                next_hour   = clock_hour;
                next_minute = clock_minute;
            end
        end else if (conf_ev) begin
            next_state = RUN;
            next_idle  = '0;
            next_load  = (state == T_HOUR) || (state == T_MIN);
            next_conf  = (state == A_HOUR) || (state == A_MIN);
        end else if (mode_ev) begin
            next_idle = '0;
            case (state)
                T_HOUR: next_state = T_MIN;
                T_MIN: begin
                    next_state  = A_HOUR;
                    next_hour   = alarm_hour;
                    next_minute = alarm_minute;
                end
                A_HOUR:  next_state = A_MIN;
                default: next_state = RUN;
            endcase
        end else if (inc_ev) begin
            next_idle = '0;
            if (state == T_HOUR || state == A_HOUR) next_hour   = inc_hour(set_hour);
            else                                    next_minute = inc_minute(set_minute);
        end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
            next_state = RUN;
            next_idle  = '0;
        end else begin
            next_idle = idle_cnt + 1'b1;
        end
        next_blink = (next_state != RUN) ? ~blink : 1'b0;
        next_field = field_of(next_state);
    end

    // Key history resets high so a key held through reset never produces an edge.
    always_ff @(posedge clk_2hz or negedge cr) begin
        if (!cr) begin
            mode_q <= 1'b1;
            inc_q  <= 1'b1;
            conf_q <= 1'b1;
        end else begin
            mode_q <= key_mode;
            inc_q  <= key_inc;
            conf_q <= key_confirm;
        end
    end

    always_ff @(posedge clk_2hz or negedge cr) begin
        if (!cr) begin
            state            <= RUN;
            set_hour         <= 8'h00;
            set_minute       <= 8'h00;
            clock_load       <= 1'b0;
            set_confirm      <= 1'b0;
            alarm_set_select <= 2'b00;
            field_sel        <= 2'b00;
            blink            <= 1'b0;
            idle_cnt         <= '0;
        end else begin
            state            <= next_state;
            set_hour         <= next_hour;
            set_minute       <= next_minute;
            clock_load       <= next_load;
            set_confirm      <= next_conf;
            alarm_set_select <= {2{next_conf}};
            field_sel        <= next_field;
            blink            <= next_blink;
            idle_cnt         <= next_idle;
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: mode sequencing, BCD increments, strobes, timeout, en and reset.
// Expected auto-repeat result follows AUTO_REPEAT_EN.
module tb_clock_set_controller;

    logic       clk_2hz = 1'b0;
    logic       cr, en, key_mode, key_inc, key_confirm;
    logic [7:0] clock_hour, clock_minute, alarm_hour, alarm_minute;
    logic [7:0] set_hour, set_minute;
    logic       clock_load, set_confirm, blink;
    logic [1:0] alarm_set_select, field_sel;

    int n_checks = 0;
    int n_fail   = 0;

    clock_set_controller dut (
        .clk_2hz          (clk_2hz),
        .cr               (cr),
        .en               (en),
        .key_mode         (key_mode),
        .key_inc          (key_inc),
        .key_confirm      (key_confirm),
        .clock_hour       (clock_hour),
        .clock_minute     (clock_minute),
        .alarm_hour       (alarm_hour),
        .alarm_minute     (alarm_minute),
        .set_hour         (set_hour),
        .set_minute       (set_minute),
        .clock_load       (clock_load),
        .set_confirm      (set_confirm),
        .alarm_set_select (alarm_set_select),
        .field_sel        (field_sel),
        .blink            (blink)
    );

    always #5 clk_2hz = ~clk_2hz;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2hz);
        #1;
    endtask

    // keys = {confirm, mode, inc}; one idle cycle first so the edge detector sees a low sample.
    task automatic press(input logic [2:0] keys);
        tick();
        {key_confirm, key_mode, key_inc} = keys;
        tick();
        {key_confirm, key_mode, key_inc} = 3'b000;
    endtask

    logic [7:0] exp_rep;

    initial begin
        cr = 1'b0; en = 1'b1;
        key_mode = 1'b1; key_inc = 1'b0; key_confirm = 1'b0;
        clock_hour = 8'h23; clock_minute = 8'h59;
        alarm_hour = 8'h07; alarm_minute = 8'h30;
        #12;
        check("rst_hour",  set_hour,   8'h00);
        check("rst_min",   set_minute, 8'h00);
        check("rst_field", {6'd0, field_sel}, 8'h00);
        check("rst_blink", {7'd0, blink}, 8'h00);
        check("rst_load",  {7'd0, clock_load}, 8'h00);
        cr = 1'b1;
        tick();
        check("held_mode_no_fire", {6'd0, field_sel}, 8'h00);
        key_mode = 1'b0;

        // Enter time-set, hour wraps 23 -> 00
        press(3'b010);
        check("thour_field", {6'd0, field_sel}, 8'h01);
        check("thour_hour",  set_hour,   8'h23);
        check("thour_min",   set_minute, 8'h59);
        check("thour_blink", {7'd0, blink}, 8'h01);
        press(3'b001);
        check("hour_wrap", set_hour, 8'h00);

        // Cycle back to RUN through every set state without any load
        press(3'b010);
        check("tmin_field", {6'd0, field_sel}, 8'h02);
        press(3'b010);
        check("ahour_field", {6'd0, field_sel}, 8'h01);
        check("ahour_preload", set_hour, 8'h07);
        press(3'b010);
        check("amin_field", {6'd0, field_sel}, 8'h02);
        press(3'b010);
        check("cycle_run_field", {6'd0, field_sel}, 8'h00);
        check("cycle_run_load",  {7'd0, clock_load}, 8'h00);
        check("cycle_run_conf",  {7'd0, set_confirm}, 8'h00);

        // Minute 59 -> 00 -> 01, then commit to the clock
        press(3'b010);
        press(3'b010);
        check("tmin2_field", {6'd0, field_sel}, 8'h02);
        press(3'b001);
        check("min_wrap", set_minute, 8'h00);
        press(3'b001);
        check("min_inc", set_minute, 8'h01);
        press(3'b100);
        check("tconf_load",  {7'd0, clock_load}, 8'h01);
        check("tconf_conf",  {7'd0, set_confirm}, 8'h00);
        check("tconf_hour",  set_hour,   8'h23);
        check("tconf_min",   set_minute, 8'h01);
        check("tconf_field", {6'd0, field_sel}, 8'h00);
        tick();
        check("tconf_load_end", {7'd0, clock_load}, 8'h00);

        // Alarm set: hour 07 -> 08, commit
        press(3'b010);
        press(3'b010);
        press(3'b010);
        check("aset_field", {6'd0, field_sel}, 8'h01);
        check("aset_hour",  set_hour,   8'h07);
        check("aset_min",   set_minute, 8'h30);
        press(3'b001);
        check("aset_inc", set_hour, 8'h08);
        press(3'b100);
        check("aconf_conf", {7'd0, set_confirm}, 8'h01);
        check("aconf_sel",  {6'd0, alarm_set_select}, 8'h03);
        check("aconf_load", {7'd0, clock_load}, 8'h00);
        check("aconf_hour", set_hour, 8'h08);
        check("aconf_field", {6'd0, field_sel}, 8'h00);
        tick();
        check("aconf_conf_end", {7'd0, set_confirm}, 8'h00);
        check("aconf_sel_end",  {6'd0, alarm_set_select}, 8'h00);

        // Idle timeout: 20 cycles in T_HOUR, blink toggles every cycle
        press(3'b010);
        check("to_enter", {6'd0, field_sel}, 8'h01);
        for (int k = 1; k < 20; k++) begin
            tick();
            check("to_field", {6'd0, field_sel}, 8'h01);
            check("to_blink", {7'd0, blink}, (k % 2 == 0) ? 8'h01 : 8'h00);
        end
        tick();
        check("to_exit_field", {6'd0, field_sel}, 8'h00);
        check("to_exit_blink", {7'd0, blink}, 8'h00);
        check("to_exit_load",  {7'd0, clock_load}, 8'h00);
        check("to_exit_conf",  {7'd0, set_confirm}, 8'h00);

        // Confirm beats mode in the same cycle
        press(3'b010);
        press(3'b010);
        press(3'b110);
        check("prio_load",  {7'd0, clock_load}, 8'h01);
        check("prio_field", {6'd0, field_sel}, 8'h00);

        // en=0 abandons an edit
        press(3'b010);
        check("en_enter", {6'd0, field_sel}, 8'h01);
        en = 1'b0;
        tick();
        check("en_field", {6'd0, field_sel}, 8'h00);
        check("en_load",  {7'd0, clock_load}, 8'h00);
        check("en_conf",  {7'd0, set_confirm}, 8'h00);
        en = 1'b1;

        // 09 -> 10 carry and non-BCD minute recovery
        clock_hour = 8'h09; clock_minute = 8'h7A;
        press(3'b010);
        press(3'b001);
        check("hour_carry", set_hour, 8'h10);
        press(3'b010);
        press(3'b001);
        check("min_nonbcd", set_minute, 8'h00);
        press(3'b100);
        check("bcd_load", {7'd0, clock_load}, 8'h01);
        check("bcd_hour", set_hour, 8'h10);

        // Hold key_inc for 8 cycles in T_MIN starting at 00
        clock_hour = 8'h23; clock_minute = 8'h59;
        press(3'b010);
        press(3'b010);
        press(3'b001);
        check("rep_start", set_minute, 8'h00);
        tick();
        key_inc = 1'b1;
        repeat (8) tick();
        key_inc = 1'b0;
`ifdef AUTO_REPEAT_EN
        exp_rep = 8'h04;
`else
        exp_rep = 8'h01;
`endif
        check("rep_min", set_minute, exp_rep);
        check("rep_field", {6'd0, field_sel}, 8'h02);

        // Asynchronous reset mid-edit
        #2 cr = 1'b0;
        #1;
        check("rst_mid_min",   set_minute, 8'h00);
        check("rst_mid_field", {6'd0, field_sel}, 8'h00);
        check("rst_mid_blink", {7'd0, blink}, 8'h00);
        cr = 1'b1;
        tick();
        check("rst_mid_after", {6'd0, field_sel}, 8'h00);
        check("rst_mid_load",  {7'd0, clock_load}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Key-driven mode controller for the digital clock.
- Sequences the user through time-set and alarm-set modes and owns the BCD working registers being edited.
- On confirm, issues one-cycle load strobes to the timekeeping counter (clock_load) and to the alarm block (set_confirm / alarm_set_select).
- Sits between the debounced front-panel keys and the clock/alarm datapaths.

Parameters:
- TIMEOUT, 20, number of idle clk_2hz cycles in any set state before abandoning back to RUN (10 s).
- HOLD_TICKS, 4, cycles key_inc must be held before auto-repeat begins (AUTO_REPEAT_EN only).

Ports:
- clk_2hz  input  1  system clock, 2 Hz; all state updates on rising edge.
- cr  input  1  asynchronous active-low reset/clear.
- en  input  1  0: FSM forced to RUN, keys ignored.
- key_mode  input  1  debounced, synchronous level; rising edge advances mode.
- key_inc  input  1  debounced level; rising edge increments the selected field.
- key_confirm  input  1  debounced level; rising edge commits the working value.
- clock_hour  input  8  current time hour, BCD.
- clock_minute  input  8  current time minute, BCD.
- alarm_hour  input  8  current alarm hour, BCD.
- alarm_minute  input  8  current alarm minute, BCD.
- set_hour  output  8  working hour, BCD.
- set_minute  output  8  working minute, BCD.
- clock_load  output  1  one-cycle strobe: load set_hour/set_minute into the clock.
- set_confirm  output  1  one-cycle strobe: load set_hour/set_minute into the alarm.
- alarm_set_select  output  2  bit1 = hour valid, bit0 = minute valid; 2'b11 only while set_confirm=1, else 2'b00.
- field_sel  output  2  00 RUN, 01 hour being edited, 10 minute being edited.
- blink  output  1  toggles every cycle in set states; 0 in RUN.

Behaviour:
- Reset (cr=0, async):
  - state=RUN; set_hour=set_minute=8'h00; all strobes=0; field_sel=00; blink=0; idle counter=0.
  - Key history registers reset to 1, so a key held through reset does not fire.
- Edge detect: an event occurs on a clk edge where key=1 and its registered previous sample=0. The action takes effect at that same edge (outputs change one cycle after the key is sampled high).
- Priority when events coincide: confirm > mode > inc. Lower-priority events in that cycle are dropped.
- States and transitions:
  - RUN --mode--> T_HOUR. Preload set_hour/set_minute from clock_hour/clock_minute.
  - T_HOUR --mode--> T_MIN. Working values kept.
  - T_MIN --mode--> A_HOUR. Preload from alarm_hour/alarm_minute; time edits discarded.
  - A_HOUR --mode--> A_MIN. Working values kept.
  - A_MIN --mode--> RUN. No load.
  - T_HOUR/T_MIN --confirm--> RUN with clock_load=1 for exactly one cycle. set_hour/set_minute hold their values during the strobe.
  - A_HOUR/A_MIN --confirm--> RUN with set_confirm=1 and alarm_set_select=2'b11 for exactly one cycle.
  - Confirm and inc in RUN are ignored.
- Increment (BCD):
  - Hour wraps 23->00; 09->10 style carries on the ones digit.
  - Minute wraps 59->00.
  - A non-BCD or out-of-range working value increments to 00.
- Idle timeout:
  - Counter clears on entering any set state and on any key event.
  - Increments each cycle in a set state.
  - When it equals TIMEOUT-1 with no event that cycle, next state is RUN with no load strobe.
- en=0: next state RUN from any state, no strobes. An in-progress edit is discarded. Edge-history registers keep sampling.
- Reset mid-edit: immediate RUN, working values cleared, no strobe.
- Outputs are registered; no combinational path from keys to outputs.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: in a set state, once key_inc has been held high for HOLD_TICKS consecutive cycles past its rising edge, the selected field increments every cycle while the key stays high. Each repeat increment clears the idle counter.
- Undefined: only the rising edge increments; holding has no effect and the hold counter is not built.

Test Plan:
- Reset, clock_hour=8'h23, clock_minute=8'h59; mode once -> field_sel=01, set_hour=8'h23, set_minute=8'h59; inc -> set_hour=8'h00.
- From T_HOUR: mode, then inc twice, then confirm -> set_minute 8'h59->8'h00->8'h01; single-cycle clock_load with set_hour=8'h23, set_minute=8'h01; state RUN, field_sel=00.
- alarm_hour=8'h07, alarm_minute=8'h30; mode x3, inc, confirm -> set_hour=8'h08; set_confirm and alarm_set_select=2'b11 for one cycle; no clock_load.
- Enter T_HOUR, no keys for 20 cycles -> returns to RUN at cycle 20; no strobes; blink toggled throughout, then 0.
- key_mode and key_confirm rise the same cycle in T_MIN -> confirm wins: clock_load pulse, RUN. Separately, en=0 mid-edit -> RUN, no strobe.
- AUTO_REPEAT_EN defined: hold key_inc 8 cycles in T_MIN from 8'h00 -> 1 edge increment plus 3 repeat increments, set_minute=8'h04. Undefined: set_minute=8'h01.
